// File: rtl/mem_pkg.sv
// Shared definitions for memory-arbiter clients: bus widths, FSM state encoding
// and sizing helpers. Also used by the arbiter and by later clients.
package mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t REL  = 2'd2;
    localparam state_t DONE = 2'd3;

    // Width of a "byte count minus one" field; never narrower than one bit.
    function automatic int len_width(input int max_bytes);
        return (max_bytes > 1) ? $clog2(max_bytes) : 1;
    endfunction

    // Number of byte beats a command with the given length field produces.
    function automatic int beat_count(input int len);
        return len + 1;
    endfunction
endpackage

// File: rtl/mem_client.sv
// Client-side initiator for the shared memory arbiter: splits one command into
// byte beats, runs the 4-phase request/ready handshake per beat, assembles reads.
module mem_client
    import mem_pkg::*;
#(
    parameter  int MAX_BYTES = 4,
    localparam int LEN_W     = len_width(MAX_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic                          cmd_we,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic [DATA_W*MAX_BYTES-1:0]   cmd_wdata,
    output logic                          rsp_valid,
    output logic [DATA_W*MAX_BYTES-1:0]   rsp_rdata,
    output logic                          request,
    output logic [ADDR_W-1:0]             addr,
    output logic                          we,
    output logic [DATA_W-1:0]             wdata,
    input  logic                          ready,
    input  logic [DATA_W-1:0]             rdata
);
    state_t                           state, state_nxt;
    logic [MAX_BYTES-1:0][DATA_W-1:0] wbuf, acc;
    logic [LEN_W-1:0]                 beat, beat_inc, len;
    logic                             we_cmd, pend, accept, last;
    logic                             cmd_ready_nxt, request_nxt, rsp_valid_nxt, we_nxt;

    assign accept    = cmd_valid & cmd_ready;
    assign beat_inc  = beat + 1'b1;
    assign last      = (beat == len);
    assign rsp_rdata = acc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // pend marks a command accepted under a stale grant: its first beat has
    // not been requested yet, so REL must not advance the beat counter.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ready ? REL : REQ;
            REQ:  if (ready)  state_nxt = REL;
            REL:  if (!ready) state_nxt = (pend || !last) ? REQ : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_nxt = (state_nxt == IDLE);
        request_nxt   = (state_nxt == REQ);
        rsp_valid_nxt = (state_nxt == DONE);
        we_nxt        = (state_nxt == REQ) & (accept ? cmd_we : we_cmd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            request   <= 1'b0;
            rsp_valid <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            acc       <= '0;
            wbuf      <= '0;
            we_cmd    <= 1'b0;
            len       <= '0;
            beat      <= '0;
            pend      <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            request   <= request_nxt;
            rsp_valid <= rsp_valid_nxt;
            we        <= we_nxt;
            if (accept) begin
                addr   <= cmd_addr;
                wdata  <= cmd_wdata[DATA_W-1:0];
                wbuf   <= cmd_wdata;
                we_cmd <= cmd_we;
                len    <= cmd_len;
                beat   <= '0;
                pend   <= ready;
                acc    <= '0;
            end else begin
                case (state)
                    REQ: if (ready && !we_cmd) acc[beat] <= rdata;
                    REL: begin
                        if (!ready) begin
                            if (pend) begin
                                pend <= 1'b0;
                            end else if (!last) begin
                                beat  <= beat_inc;
                                addr  <= addr + 8'd1;
                                wdata <= wbuf[beat_inc];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_client.sv
// Scoreboard bench for mem_client: randomized commands against a byte-memory
// reference, with a behavioural arbiter and a protocol/response monitor.
module tb_mem_client;
    import mem_pkg::beat_count;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [7:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata, rsp_rdata;
    logic        rsp_valid, request, we, ready;
    logic [7:0]  addr, wdata, rdata;

    always #5 clk = ~clk;

    mem_client #(.MAX_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_we(cmd_we), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .request(request), .addr(addr), .we(we), .wdata(wdata),
        .ready(ready), .rdata(rdata)
    );

    typedef struct packed {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
    } beat_t;

    logic [7:0]  mem     [256];   // memory behind the arbiter
    logic [7:0]  ref_mem [256];   // bench's view of what memory must contain
    beat_t       exp_beats[$];
    logic [31:0] exp_rsp[$];
    int          n_cmp = 0, n_fail = 0;
    int          grant_delay = 1, rel_delay = 0;
    bit          stale_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Arbiter: grants after grant_delay cycles, releases rel_delay cycles after
    // request drops; stale_hold forces ready high with no owner.
    initial begin : arbiter
        int    cnt;
        bit    granted;
        beat_t b;
        cnt = 0; granted = 1'b0;
        ready = 1'b0; rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (stale_hold) begin
                ready = 1'b1; granted = 1'b0; cnt = 0;
            end else if (!granted) begin
                if (ready) ready = 1'b0;
                else if (!request) cnt = 0;
                else if (cnt >= grant_delay) begin
                    if (exp_beats.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL beat_unexpected: addr %0h, no beat required", addr);
                    end else begin
                        b = exp_beats.pop_front();
                        check("beat_addr", 32'(addr), 32'(b.a));
                        check("beat_we", 32'(we), 32'(b.w));
                        if (b.w) check("beat_wdata", 32'(wdata), 32'(b.d));
                    end
                    rdata = mem[addr];
                    if (we) mem[addr] = wdata;
                    ready = 1'b1; granted = 1'b1; cnt = 0;
                end else cnt++;
            end else if (!request) begin
                if (cnt >= rel_delay) begin
                    ready = 1'b0; granted = 1'b0; cnt = 0;
                end else cnt++;
            end
        end
    end

    initial begin : monitor
        logic       pr, pv, pw;
        logic [7:0] pa, pd;
        pr = 1'b0; pv = 1'b0; pw = 1'b0; pa = 8'h00; pd = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                if (request && !pr) check("req_rise_ready_low", 32'(ready), 32'd0);
                if (!request && pr) check("req_fall_ready_high", 32'(ready), 32'd1);
                if (request && pr) begin
                    check("beat_addr_stable", 32'(addr), 32'(pa));
                    check("beat_we_stable", 32'(we), 32'(pw));
                    check("beat_wdata_stable", 32'(wdata), 32'(pd));
                end
                if (we) check("we_needs_request", 32'(request), 32'd1);
                if (rsp_valid) begin
                    if (pv) check("rsp_one_cycle", 32'(pv), 32'd0);
                    check("req_low_at_rsp", 32'(request), 32'd0);
                    if (exp_rsp.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL rsp_unexpected: rsp_valid with rdata %0h, none required", rsp_rdata);
                    end else begin
                        check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
                    end
                end
            end
            pr = request; pv = rsp_valid; pw = we; pa = addr; pd = wdata;
        end
    end

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        mem[a] = v; ref_mem[a] = v;
    endtask

    task automatic issue(input logic [7:0] a, input logic w, input logic [1:0] l,
                         input logic [31:0] wd, input bit junk);
        logic [31:0] e;
        logic [7:0]  b;
        int          t;
        e = '0;
        for (int i = 0; i < beat_count(int'(l)); i++) begin
            b = a + 8'(i);
            exp_beats.push_back({b, w, wd[8*i +: 8]});
            if (w) ref_mem[b] = wd[8*i +: 8];
            else   e[8*i +: 8] = ref_mem[b];
        end
        exp_rsp.push_back(e);
        t = 0;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_ready_timeout: cmd_ready %0b, required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = a; cmd_we = w; cmd_len = l; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (junk && !cmd_ready) begin
            cmd_valid = 1'b1; cmd_addr = 8'($urandom); cmd_we = 1'($urandom);
            cmd_len = 2'($urandom); cmd_wdata = $urandom;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit);
        int t;
        t = 0;
        while (exp_rsp.size() != 0 && t < limit) begin @(negedge clk); t++; end
        if (exp_rsp.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_rsp.size());
            exp_rsp.delete();
        end
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        exp_beats.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v; ref_mem[i] = v;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0;
        cmd_len = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_request", 32'(request), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // single-beat read
        set_mem(8'h10, 8'hA5);
        grant_delay = 2; rel_delay = 0;
        issue(8'h10, 1'b0, 2'd0, 32'h0, 1'b0);
        wait_done(200);

        // four-beat read wrapping through 0xFF
        set_mem(8'hFE, 8'h11); set_mem(8'hFF, 8'h22);
        set_mem(8'h00, 8'h33); set_mem(8'h01, 8'h44);
        issue(8'hFE, 1'b0, 2'd3, 32'h0, 1'b0);
        wait_done(300);

        // two-beat write, then confirm the bytes landed
        issue(8'h40, 1'b1, 2'd1, 32'h0000BEEF, 1'b1);
        wait_done(300);
        check("mem_40", 32'(mem[8'h40]), 32'hEF);
        check("mem_41", 32'(mem[8'h41]), 32'hBE);

        // stale grant present at accept
        stale_hold = 1'b1;
        repeat (2) @(negedge clk);
        issue(8'h60, 1'b0, 2'd1, 32'h0, 1'b0);
        repeat (6) begin
            check("stale_no_request", 32'(request), 32'd0);
            @(negedge clk);
        end
        stale_hold = 1'b0;
        wait_done(300);

        // reset during the second beat of a four-beat read
        grant_delay = 3;
        issue(8'h80, 1'b0, 2'd3, 32'h0, 1'b0);
        t = 0;
        while (!(request && addr == 8'h81) && t < 200) begin @(negedge clk); t++; end
        check("reached_beat2", 32'(addr), 32'h81);
        rst = 1'b1;
        exp_rsp.delete(); exp_beats.delete();
        @(negedge clk);
        check("abort_request", 32'(request), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready_back", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        issue(8'h20, 1'b0, 2'd2, 32'h0, 1'b0);
        wait_done(300);

        // stalled arbiter
        grant_delay = 20;
        issue(8'h33, 1'b0, 2'd1, 32'h0, 1'b0);
        wait_done(500);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            grant_delay = $urandom_range(0, 3);
            rel_delay   = $urandom_range(0, 3);
            issue(8'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
            wait_done(300);
        end

        // read back a span to catch stray or missing writes
        grant_delay = 0; rel_delay = 0;
        for (int k = 0; k < 16; k++) begin
            issue(8'(k * 4 + 8'h40), 1'b0, 2'd3, 32'h0, 1'b0);
            wait_done(300);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
